// File: rtl/approx_add_err_monitor_if.sv
// Sample handshake between the approximate adder under test and its error monitor.
interface approx_add_err_monitor_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_cin;
  logic [7:0] in_sum;
  logic       in_cout;

  modport master (output in_valid, in_a, in_b, in_cin, in_sum, in_cout, input in_ready);
  modport slave  (input in_valid, in_a, in_b, in_cin, in_sum, in_cout, output in_ready);
endinterface

// File: rtl/approx_add_err_monitor.sv
// Scores an 8-bit approximate adder: 3-stage pipe (capture, ED, retire) into saturating stats.
// Optional signed bias accumulator when ERR_BIAS_EN is defined.
module approx_add_err_monitor #(
  parameter int CNT_W = 17,
  parameter int ACC_W = 25
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  approx_add_err_monitor_if.slave in_if,
  output logic [CNT_W-1:0]       sample_cnt_o,
  output logic [CNT_W-1:0]       err_cnt_o,
  output logic [ACC_W-1:0]       abs_err_sum_o,
  output logic [8:0]             max_err_o,
  output logic [7:0]             max_err_a_o,
  output logic [7:0]             max_err_b_o,
  output logic [8:0]             last_ed_o,
  output logic                   last_ed_valid_o
`ifdef ERR_BIAS_EN
  ,
  output logic signed [ACC_W:0]  err_bias_sum_o
`endif
);

  localparam logic [CNT_W:0] FILL_MAX = {1'b0, {CNT_W{1'b1}}};
  localparam int             SW       = ((ACC_W > 9) ? ACC_W : 9) + 1;
  localparam logic [SW-1:0]  ACC_MAX  = SW'({ACC_W{1'b1}});

  // vld_q[0]: S1 holds a sample, vld_q[1]: S2 holds a sample
  logic [1:0]       vld_q;
  logic [7:0]       a1_q, b1_q, sum1_q;
  logic             cin1_q, cout1_q;
  logic [8:0]       ed2_q;
  logic [7:0]       a2_q, b2_q;

  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [ACC_W-1:0] abs_err_sum_q, abs_err_sum_d;
  logic [8:0]       max_err_q, max_err_d;
  logic [7:0]       max_err_a_q, max_err_a_d;
  logic [7:0]       max_err_b_q, max_err_b_d;
  logic [8:0]       last_ed_q, last_ed_d;
  logic             last_ed_valid_q, last_ed_valid_d;

  logic [8:0]       exact, approx, ed;
  logic [SW-1:0]    abs_ext;
  logic [CNT_W:0]   fill;
  logic             full, accept;

  // Counting in-flight samples keeps the counter from ever wrapping.
  assign fill   = {1'b0, sample_cnt_q} + {{CNT_W{1'b0}}, vld_q[0]} + {{CNT_W{1'b0}}, vld_q[1]};
  assign full   = (fill == FILL_MAX);
  assign in_if.in_ready = !rst_i && !clr_i && !full;
  assign accept = in_if.in_valid && in_if.in_ready;

  always_comb begin
    exact  = {1'b0, a1_q} + {1'b0, b1_q} + {8'd0, cin1_q};
    approx = {cout1_q, sum1_q};
    ed     = (exact >= approx) ? (exact - approx) : (approx - exact);
  end

  always_comb begin
    sample_cnt_d    = sample_cnt_q;
    err_cnt_d       = err_cnt_q;
    abs_err_sum_d   = abs_err_sum_q;
    max_err_d       = max_err_q;
    max_err_a_d     = max_err_a_q;
    max_err_b_d     = max_err_b_q;
    last_ed_d       = last_ed_q;
    last_ed_valid_d = 1'b0;
    abs_ext         = SW'(abs_err_sum_q) + SW'(ed2_q);
    if (vld_q[1]) begin
      sample_cnt_d = sample_cnt_q + CNT_W'(1);
      if (ed2_q != 9'd0) err_cnt_d = err_cnt_q + CNT_W'(1);
      abs_err_sum_d = (abs_ext > ACC_MAX) ? {ACC_W{1'b1}} : abs_ext[ACC_W-1:0];
      if (ed2_q > max_err_q) begin
        max_err_d   = ed2_q;
        max_err_a_d = a2_q;
        max_err_b_d = b2_q;
      end
      last_ed_d       = ed2_q;
      last_ed_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      vld_q           <= 2'b00;
      sample_cnt_q    <= '0;
      err_cnt_q       <= '0;
      abs_err_sum_q   <= '0;
      max_err_q       <= '0;
      max_err_a_q     <= '0;
      max_err_b_q     <= '0;
      last_ed_q       <= '0;
      last_ed_valid_q <= 1'b0;
    end else begin
      vld_q           <= {vld_q[0], accept};
      sample_cnt_q    <= sample_cnt_d;
      err_cnt_q       <= err_cnt_d;
      abs_err_sum_q   <= abs_err_sum_d;
      max_err_q       <= max_err_d;
      max_err_a_q     <= max_err_a_d;
      max_err_b_q     <= max_err_b_d;
      last_ed_q       <= last_ed_d;
      last_ed_valid_q <= last_ed_valid_d;
    end
  end

  // Datapath registers are qualified by the valid bits, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      a1_q    <= in_if.in_a;
      b1_q    <= in_if.in_b;
      cin1_q  <= in_if.in_cin;
      sum1_q  <= in_if.in_sum;
      cout1_q <= in_if.in_cout;
    end
    if (vld_q[0]) begin
      ed2_q <= ed;
      a2_q  <= a1_q;
      b2_q  <= b1_q;
    end
  end

  assign sample_cnt_o    = sample_cnt_q;
  assign err_cnt_o       = err_cnt_q;
  assign abs_err_sum_o   = abs_err_sum_q;
  assign max_err_o       = max_err_q;
  assign max_err_a_o     = max_err_a_q;
  assign max_err_b_o     = max_err_b_q;
  assign last_ed_o       = last_ed_q;
  assign last_ed_valid_o = last_ed_valid_q;

`ifdef ERR_BIAS_EN
  localparam int                    BW       = (((ACC_W + 1) > 10) ? (ACC_W + 1) : 10) + 1;
  localparam logic signed [BW-1:0]  BIAS_MAX = BW'({ACC_W{1'b1}});
  localparam logic signed [BW-1:0]  BIAS_MIN = ~BIAS_MAX;

  logic signed [9:0]    dif, dif2_q;
  logic signed [ACC_W:0] bias_q, bias_d;
  logic signed [BW-1:0]  bias_ext;

  always_comb begin
    dif      = $signed({1'b0, approx}) - $signed({1'b0, exact});
    bias_ext = BW'(bias_q) + BW'(dif2_q);
    bias_d   = bias_q;
    if (vld_q[1]) begin
      if (bias_ext > BIAS_MAX)      bias_d = BIAS_MAX[ACC_W:0];
      else if (bias_ext < BIAS_MIN) bias_d = BIAS_MIN[ACC_W:0];
      else                          bias_d = bias_ext[ACC_W:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (vld_q[0]) dif2_q <= dif;
    if (rst_i || clr_i) bias_q <= '0;
    else                bias_q <= bias_d;
  end

  assign err_bias_sum_o = bias_q;
`endif

endmodule

// File: tb/tb_approx_add_err_monitor.sv
// Randomized self-checking bench: two monitors (full-size and CNT_W=4/ACC_W=10) vs a transaction model.
module tb_approx_add_err_monitor;
  logic clk = 1'b0;
  logic rst, clr, rst4, clr4;
  always #5 clk = ~clk;

  approx_add_err_monitor_if ifa ();
  approx_add_err_monitor_if ifb ();

  logic [16:0] cnt_a, err_a;
  logic [24:0] abs_a;
  logic [8:0]  max_a, led_a;
  logic [7:0]  ma_a, mb_a;
  logic        lv_a;
  logic [3:0]  cnt_b, err_b;
  logic [9:0]  abs_b;
  logic [8:0]  max_b, led_b;
  logic [7:0]  ma_b, mb_b;
  logic        lv_b;
`ifdef ERR_BIAS_EN
  logic signed [25:0] bias_a;
  logic signed [10:0] bias_b;
`endif

  approx_add_err_monitor dut (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .in_if(ifa),
    .sample_cnt_o(cnt_a), .err_cnt_o(err_a), .abs_err_sum_o(abs_a),
    .max_err_o(max_a), .max_err_a_o(ma_a), .max_err_b_o(mb_a),
    .last_ed_o(led_a), .last_ed_valid_o(lv_a)
`ifdef ERR_BIAS_EN
    , .err_bias_sum_o(bias_a)
`endif
  );

  approx_add_err_monitor #(.CNT_W(4), .ACC_W(10)) dut4 (
    .clk_i(clk), .rst_i(rst4), .clr_i(clr4), .in_if(ifb),
    .sample_cnt_o(cnt_b), .err_cnt_o(err_b), .abs_err_sum_o(abs_b),
    .max_err_o(max_b), .max_err_a_o(ma_b), .max_err_b_o(mb_b),
    .last_ed_o(led_b), .last_ed_valid_o(lv_b)
`ifdef ERR_BIAS_EN
    , .err_bias_sum_o(bias_b)
`endif
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: statistics plus a list of accepted samples with their age in edges.
  typedef struct { int a; int b; int cin; int sum; int cout; int age; } smp_t;
  smp_t   pend[$];
  bit     cur;
  longint cnt_max, acc_max;
  longint m_cnt, m_err, m_abs, m_max, m_ma, m_mb, m_led, m_bias;
  bit     m_lv;

  task automatic model_clear();
    m_cnt = 0; m_err = 0; m_abs = 0; m_max = 0; m_ma = 0; m_mb = 0;
    m_led = 0; m_lv = 0; m_bias = 0;
    pend.delete();
  endtask

  task automatic retire(input smp_t s);
    longint ex, ap, ed;
    ex = s.a + s.b + s.cin;
    ap = s.cout * 256 + s.sum;
    ed = (ex > ap) ? ex - ap : ap - ex;
    m_cnt++;
    if (ed != 0) m_err++;
    m_abs = (m_abs + ed > acc_max) ? acc_max : m_abs + ed;
    if (ed > m_max) begin m_max = ed; m_ma = s.a; m_mb = s.b; end
    m_led = ed;
    m_lv  = 1;
    m_bias = m_bias + (ap - ex);
    if (m_bias > acc_max) m_bias = acc_max;
    if (m_bias < -(acc_max + 1)) m_bias = -(acc_max + 1);
  endtask

  task automatic step(input bit v, input logic [7:0] a, input logic [7:0] b, input bit cin,
                      input logic [7:0] sum, input bit cout, input bit r, input bit c);
    bit exp_rdy, acc;
    if (!cur) begin
      rst = r; clr = c; rst4 = 1'b1; clr4 = 1'b0; ifb.in_valid = 1'b0;
      ifa.in_valid = v; ifa.in_a = a; ifa.in_b = b; ifa.in_cin = cin;
      ifa.in_sum = sum; ifa.in_cout = cout;
    end else begin
      rst = 1'b1; clr = 1'b0; rst4 = r; clr4 = c; ifa.in_valid = 1'b0;
      ifb.in_valid = v; ifb.in_a = a; ifb.in_b = b; ifb.in_cin = cin;
      ifb.in_sum = sum; ifb.in_cout = cout;
    end
    #1;
    exp_rdy = !r && !c && (m_cnt + pend.size() != cnt_max);
    chk("in_ready", cur ? ifb.in_ready : ifa.in_ready, exp_rdy);
    acc = v && exp_rdy;
    @(posedge clk);
    if (r || c) model_clear();
    else begin
      m_lv = 0;
      foreach (pend[i]) pend[i].age++;
      if (pend.size() > 0 && pend[0].age == 2) begin
        retire(pend[0]);
        void'(pend.pop_front());
      end
      if (acc) pend.push_back('{int'(a), int'(b), int'(cin), int'(sum), int'(cout), 0});
    end
    #1;
    chk("sample_cnt",    cur ? longint'(cnt_b) : longint'(cnt_a), m_cnt);
    chk("err_cnt",       cur ? longint'(err_b) : longint'(err_a), m_err);
    chk("abs_err_sum",   cur ? longint'(abs_b) : longint'(abs_a), m_abs);
    chk("max_err",       cur ? longint'(max_b) : longint'(max_a), m_max);
    chk("max_err_a",     cur ? longint'(ma_b)  : longint'(ma_a),  m_ma);
    chk("max_err_b",     cur ? longint'(mb_b)  : longint'(mb_a),  m_mb);
    chk("last_ed",       cur ? longint'(led_b) : longint'(led_a), m_led);
    chk("last_ed_valid", cur ? longint'(lv_b)  : longint'(lv_a),  longint'(m_lv));
`ifdef ERR_BIAS_EN
    chk("err_bias_sum",  cur ? longint'(bias_b) : longint'(bias_a), m_bias);
`endif
  endtask

  // mode 0: exact, 1: random low bits (approximate LSBs), 2: arbitrary 9-bit result
  task automatic rnd_step(input int mode, input int pv, input bit r, input bit c);
    logic [7:0] a, b;
    logic [8:0] ap, mask;
    bit         cin, v;
    int         k;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    ap = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    if (mode == 1) begin
      k = $urandom_range(0, 8);
      mask = 9'((1 << k) - 1);
      ap = (ap & ~mask) | (9'($urandom) & mask);
    end else if (mode == 2) ap = 9'($urandom_range(0, 511));
    v = ($urandom_range(0, 99) < pv);
    step(v, a, b, cin, ap[7:0], ap[8], r, c);
  endtask

  initial begin
    cur = 0; cnt_max = (1 << 17) - 1; acc_max = (1 << 25) - 1;
    model_clear();
    rst = 1; clr = 0; rst4 = 1; clr4 = 0;
    ifa.in_valid = 0; ifb.in_valid = 0;
    // reset, then exact results
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 8'd3, 8'd4, 0, 8'd7, 0, 0, 0);
    step(1, 8'd255, 8'd1, 0, 8'd0, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
    // single error, then a tie that must not replace the stored operands
    step(1, 8'h1F, 8'h01, 0, 8'h1F, 0, 0, 0);
    step(1, 8'h0F, 8'h01, 0, 8'h0F, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
    // back-to-back ED 5, 200, 200 from a cleared state
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 8'd10, 8'd0, 0, 8'd15, 0, 0, 0);
    step(1, 8'd100, 8'd100, 0, 8'd0, 0, 0, 0);
    step(1, 8'd50, 8'd150, 0, 8'd0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
    // clr while two samples are in flight and a third is presented
    step(1, 8'd1, 8'd2, 0, 8'd9, 0, 0, 0);
    step(1, 8'd7, 8'd7, 1, 8'd0, 0, 0, 0);
    step(1, 8'd20, 8'd30, 0, 8'd40, 0, 0, 1);
    step(1, 8'd20, 8'd30, 0, 8'd40, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
    // randomized sweep with occasional clr / rst
    for (int i = 0; i < 400; i++)
      rnd_step(i % 3, 80, ($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0));
    // reset mid-stream, then a sample one below exact
    rnd_step(1, 100, 0, 0);
    rnd_step(1, 100, 0, 0);
    rnd_step(1, 100, 1, 0);
    step(1, 8'd0, 8'd0, 1, 8'd0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
    // small instance: counter stall at 15 and accumulator saturation at 1023
    cur = 1; cnt_max = 15; acc_max = 1023;
    model_clear();
    step(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) rnd_step(2, 100, 0, 0);
    repeat (2) rnd_step(2, 100, 0, 0);
    rnd_step(2, 100, 0, 1);
    for (int i = 0; i < 40; i++) rnd_step(i % 3, 70, 0, ($urandom_range(0, 29) == 0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
